// File: rtl/polytris_pkg.sv
// polytris_pkg: shared board geometry, row patterns and line-clear engine states
package polytris_pkg;
    localparam int ROWS_DEF = 24;
    localparam int CELL_W = 2;
    localparam int CELLS = 16;
    localparam logic [31:0] WALL_ROW = 32'hFC00_003F;
    localparam logic [31:0] FLOOR_ROW = 32'hFFFF_FFFF;
    localparam logic [31:0] WALL_MASK = 32'hFC00_003F;
    typedef logic [CELL_W-1:0] cell_t;
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;
endpackage

// File: rtl/board_row_full.sv
// board_row_full: flags a row whose sixteen cells are all non-empty
module board_row_full
    import polytris_pkg::*;
(
    input  logic [31:0] row,
    output logic        full
);
    logic [CELLS-1:0] nz;
    for (genvar k = 0; k < CELLS; k++) begin : g_cell
        cell_t c;
        assign c = row[CELL_W*k +: CELL_W];
        assign nz[k] = |c;
    end
    assign full = &nz;
endmodule

// File: rtl/board_row_store.sv
// board_row_store: board row RAM with line-clear engine; BOARD_LINE_TOTAL_EN adds the LINES_TOTAL counter
module board_row_store
    import polytris_pkg::*;
#(
    parameter int ROWS = ROWS_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] RAM_ROW_ADDR,
    input  logic        RAM_RE,
    input  logic        RAM_WE,
    input  logic [31:0] RAM_WRITEDATA,
    output logic [31:0] RAM_READDATA,
    output logic        RAM_RVALID,
    output logic        RAM_BUSY,
    input  logic        CLEARLINE,
    input  logic        CLEARALL,
    output logic        CLEAR_DONE,
    output logic [2:0]  LINES_CLEARED,
    output logic [15:0] LINES_TOTAL
);
    localparam int AW = $clog2(ROWS - 1);
    localparam logic [10:0] LAST = 11'(ROWS - 1);
    localparam logic [AW-1:0] TOP = AW'(ROWS - 2);
    // the floor row is constant, so only rows 0..ROWS-2 are stored
    logic [31:0] rows [ROWS-1];
    state_t state;
    logic [AW-1:0] sp, pp, idx;
    logic [2:0] cnt;
    logic row_full, in_range, rd, wr;
    assign idx = RAM_ROW_ADDR[AW-1:0];
    assign in_range = RAM_ROW_ADDR < LAST;
    assign rd = RAM_RE && !RAM_BUSY;
    assign wr = RAM_WE && !RAM_BUSY && in_range;

    board_row_full u_full (.row(rows[sp]), .full(row_full));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROWS - 1; i++) rows[i] <= WALL_ROW;
            state <= IDLE;
            sp <= '0;
            pp <= '0;
            cnt <= '0;
            RAM_READDATA <= '0;
            RAM_RVALID <= 1'b0;
            RAM_BUSY <= 1'b0;
            CLEAR_DONE <= 1'b0;
            LINES_CLEARED <= '0;
        end else begin
            RAM_RVALID <= rd;
            if (rd) RAM_READDATA <= in_range ? rows[idx] : FLOOR_ROW;
            CLEAR_DONE <= 1'b0;
            if (CLEARALL) begin
                for (int i = 0; i < ROWS - 1; i++) rows[i] <= WALL_ROW;
                state <= IDLE;
                RAM_BUSY <= 1'b0;
            end else begin
                if (wr) rows[idx] <= RAM_WRITEDATA | WALL_MASK;
                case (state)
                    IDLE: if (CLEARLINE) begin
                        state <= SCAN;
                        sp <= TOP;
                        cnt <= '0;
                        RAM_BUSY <= 1'b1;
                    end
                    SCAN: if (row_full) begin
                        pp <= sp;
                        state <= SHIFT;
                    end else if (sp == '0) begin
                        state <= DONE;
                    end else begin
                        sp <= sp - AW'(1);
                    end
                    // returning to SCAN at the same pointer re-tests the row that just dropped in
                    SHIFT: if (pp == '0) begin
                        rows[0] <= WALL_ROW;
                        cnt <= cnt + 3'(cnt != 3'd7);
                        state <= SCAN;
                    end else begin
                        rows[pp] <= rows[pp - AW'(1)];
                        pp <= pp - AW'(1);
                    end
                    DONE: begin
                        CLEAR_DONE <= 1'b1;
                        LINES_CLEARED <= cnt;
                        RAM_BUSY <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef BOARD_LINE_TOTAL_EN
    logic [16:0] sum;
    assign sum = {1'b0, LINES_TOTAL} + 17'(cnt);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) LINES_TOTAL <= '0;
        else if (state == DONE && !CLEARALL) LINES_TOTAL <= sum[16] ? 16'hFFFF : sum[15:0];
    end
`else
    assign LINES_TOTAL = 16'd0;
`endif
endmodule

// File: tb/tb_board_row_store.sv
// tb_board_row_store: scoreboard bench for board_row_store reads, writes and line clears
module tb_board_row_store;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] RAM_ROW_ADDR = '0;
    logic        RAM_RE = 1'b0;
    logic        RAM_WE = 1'b0;
    logic [31:0] RAM_WRITEDATA = '0;
    logic [31:0] RAM_READDATA;
    logic        RAM_RVALID;
    logic        RAM_BUSY;
    logic        CLEARLINE = 1'b0;
    logic        CLEARALL = 1'b0;
    logic        CLEAR_DONE;
    logic [2:0]  LINES_CLEARED;
    logic [15:0] LINES_TOTAL;

    localparam logic [31:0] WALL = 32'hFC00_003F;
    localparam logic [31:0] FLOOR = 32'hFFFF_FFFF;

    int total = 0;
    int bad = 0;
    logic [31:0] rd_q [$];
    logic [18:0] cl_q [$];
    logic [31:0] e_rd;
    logic [18:0] e_cl;
    logic [15:0] exp_tot = '0;

    board_row_store dut (
        .clk(clk), .reset_n(reset_n), .RAM_ROW_ADDR(RAM_ROW_ADDR), .RAM_RE(RAM_RE),
        .RAM_WE(RAM_WE), .RAM_WRITEDATA(RAM_WRITEDATA), .RAM_READDATA(RAM_READDATA),
        .RAM_RVALID(RAM_RVALID), .RAM_BUSY(RAM_BUSY), .CLEARLINE(CLEARLINE),
        .CLEARALL(CLEARALL), .CLEAR_DONE(CLEAR_DONE), .LINES_CLEARED(LINES_CLEARED),
        .LINES_TOTAL(LINES_TOTAL)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && RAM_RVALID) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL read_unexpected: rvalid with data %h, none required", RAM_READDATA);
            end else begin
                e_rd = rd_q.pop_front();
                if (RAM_READDATA !== e_rd) begin
                    bad++;
                    $display("FAIL read_data: got %h required %h", RAM_READDATA, e_rd);
                end
            end
        end
        if (reset_n && CLEAR_DONE) begin
            total++;
            if (cl_q.size() == 0) begin
                bad++;
                $display("FAIL clear_unexpected: clear_done with lines %0d, none required", LINES_CLEARED);
            end else begin
                e_cl = cl_q.pop_front();
                if ({LINES_CLEARED, LINES_TOTAL} !== e_cl) begin
                    bad++;
                    $display("FAIL clear_result: got lines=%0d total=%0d required lines=%0d total=%0d",
                             LINES_CLEARED, LINES_TOTAL, e_cl[18:16], e_cl[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [10:0] a, input logic [31:0] exp);
        RAM_ROW_ADDR = a;
        RAM_RE = 1'b1;
        rd_q.push_back(exp);
        tick();
        RAM_RE = 1'b0;
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d);
        RAM_ROW_ADDR = a;
        RAM_WRITEDATA = d;
        RAM_WE = 1'b1;
        tick();
        RAM_WE = 1'b0;
    endtask

    task automatic clearall();
        CLEARALL = 1'b1;
        tick();
        CLEARALL = 1'b0;
    endtask

    task automatic clearline(input logic [2:0] n);
`ifdef BOARD_LINE_TOTAL_EN
        exp_tot = exp_tot + 16'(n);
`endif
        cl_q.push_back({n, exp_tot});
        CLEARLINE = 1'b1;
        tick();
        CLEARLINE = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && RAM_BUSY; i++) tick();
        chk("busy_timeout", {31'd0, RAM_BUSY}, 32'd0);
        tick();
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_readdata", RAM_READDATA, 32'd0);
        chk("rst_flags", {28'd0, RAM_RVALID, RAM_BUSY, CLEAR_DONE, 1'b0}, 32'd0);
        chk("rst_counts", {13'd0, LINES_CLEARED, LINES_TOTAL}, 32'd0);
        reset_n = 1'b1;
        tick();

        rd(5, WALL);
        rd(30, FLOOR);
        rd(23, FLOOR);
        wr(3, 32'h0000_0000);
        rd(3, WALL);
        wr(23, 32'h0000_0000);
        rd(23, FLOOR);
        wr(4, 32'h1234_5678);
        rd(4, 32'hFE34_567F);

        RAM_ROW_ADDR = 7;
        RAM_WRITEDATA = FLOOR;
        RAM_RE = 1'b1;
        RAM_WE = 1'b1;
        rd_q.push_back(WALL);
        tick();
        RAM_RE = 1'b0;
        RAM_WE = 1'b0;
        rd(7, FLOOR);

        clearall();
        rd(7, WALL);
        rd(4, WALL);

        wr(22, FLOOR);
        wr(21, 32'hFC55_403F);
        clearline(3'd1);
        chk("busy_high", {31'd0, RAM_BUSY}, 32'd1);
        tick();
        RAM_ROW_ADDR = 10;
        RAM_WRITEDATA = FLOOR;
        RAM_RE = 1'b1;
        RAM_WE = 1'b1;
        tick();
        RAM_RE = 1'b0;
        RAM_WE = 1'b0;
        wait_idle();
        rd(22, 32'hFC55_403F);
        rd(21, WALL);
        rd(0, WALL);
        rd(10, WALL);

        clearall();
        for (int r = 19; r <= 22; r++) wr(11'(r), FLOOR);
        clearline(3'd4);
        wait_idle();
        rd(22, WALL);
        rd(19, WALL);

        clearall();
        wr(22, FLOOR);
        wr(5, 32'h0000_0100);
        rd(5, 32'hFC00_013F);
        CLEARLINE = 1'b1;
        tick();
        CLEARLINE = 1'b0;
        repeat (5) tick();
        chk("busy_mid_shift", {31'd0, RAM_BUSY}, 32'd1);
        clearall();
        chk("busy_after_clearall", {31'd0, RAM_BUSY}, 32'd0);
        repeat (3) tick();
        chk("lines_held", {29'd0, LINES_CLEARED}, 32'd4);
        rd(5, WALL);
        rd(22, WALL);
        rd(21, WALL);

        clearline(3'd0);
        wait_idle();

        repeat (4) tick();
        chk("read_queue_empty", rd_q.size(), 32'd0);
        chk("clear_queue_empty", cl_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/board_row_store.md
BOARD_ROW_STORE -- requirements
Module: board_row_store

Interface
REQ-001 SHALL have parameter ROWS, default 24, meaning the number of board rows (row 0 top, row ROWS-1 floor).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port RAM_ROW_ADDR, input, 11, row index of the requested access.
REQ-005 SHALL have port RAM_RE, input, 1, read request.
REQ-006 SHALL have port RAM_WE, input, 1, write request.
REQ-007 SHALL have port RAM_WRITEDATA, input, 32, row write data: 16 cells x 2 bits, cell k at bits [2k+1:2k], 2'b00 = empty.
REQ-008 SHALL have port RAM_READDATA, output, 32, registered row read data.
REQ-009 SHALL have port RAM_RVALID, output, 1, one-cycle pulse qualifying RAM_READDATA.
REQ-010 SHALL have port RAM_BUSY, output, 1, high while RAM_RE/RAM_WE are ignored.
REQ-011 SHALL have port CLEARLINE, input, 1, single-cycle request to run the line-clear engine.
REQ-012 SHALL have port CLEARALL, input, 1, single-cycle request to reinitialise the board.
REQ-013 SHALL have port CLEAR_DONE, output, 1, one-cycle pulse at the end of a line-clear run.
REQ-014 SHALL have port LINES_CLEARED, output, 3, rows removed in the last run, held until the next CLEAR_DONE.
REQ-015 SHALL have port LINES_TOTAL, output, 16, running cleared-line count.

Function
REQ-016 SHALL use these row patterns: the wall row has cells 0-2 and 13-15 = 2'b11 and cells 3-12 = 2'b00; the floor row has all cells 2'b11.
REQ-017 SHALL give reads a latency of 1: RAM_RE high at cycle N (not busy) drives RAM_READDATA = row[addr] and RAM_RVALID = 1 at cycle N+1.
REQ-018 SHALL return the floor pattern for a read with addr >= ROWS.
REQ-019 SHALL update row[addr] at the clock edge for RAM_WE with addr < ROWS; wall cells 0-2 and 13-15 are forced to 2'b11 regardless of data.
REQ-020 SHALL ignore writes with addr >= ROWS and SHALL never write row ROWS-1.
REQ-021 SHALL return the pre-write data when RAM_RE and RAM_WE target the same row in one cycle.
REQ-022 SHALL ignore RAM_RE and RAM_WE while RAM_BUSY is high: no write occurs and RAM_RVALID stays 0.
REQ-023 SHALL implement the FSM IDLE, SCAN, SHIFT, DONE.
REQ-024 SHALL move IDLE->SCAN on CLEARLINE, with the scan pointer set to ROWS-2, the run counter cleared and RAM_BUSY high from the next cycle.
REQ-025 SHALL, in SCAN, test one row per cycle; a row is full when all 16 cells are non-zero.
REQ-026 SHALL, in SCAN, go to SHIFT with the shift pointer set to the scan pointer on a full row; otherwise it decrements the scan pointer.
REQ-027 SHALL, in SCAN, go to DONE after testing row 0 and finding it not full.
REQ-028 SHALL, in SHIFT, perform row[p] = row[p-1] and decrement p, one row per cycle.
REQ-029 SHALL, in SHIFT at p = 0, write row[0] = wall row, increment the run counter (saturating at 7) and return to SCAN at the same scan pointer, so a newly dropped full row is re-tested.
REQ-030 SHALL, in DONE, pulse CLEAR_DONE for one cycle, load LINES_CLEARED, add the run count to LINES_TOTAL (saturating at 16'hFFFF) and return to IDLE.
REQ-031 SHALL deassert RAM_BUSY in the cycle after DONE.
REQ-032 SHALL ignore CLEARLINE when not in IDLE.
REQ-033 SHALL, on CLEARALL in any state, load rows 0..ROWS-2 with the wall row and ROWS-1 with the floor row in one cycle, abort any run without pulsing CLEAR_DONE, go to IDLE, and leave LINES_TOTAL unchanged.
REQ-034 SHALL give CLEARALL priority over RAM_WE and CLEARLINE in the same cycle.

Reset
REQ-035 SHALL, on reset_n low, immediately load the board as for CLEARALL, set the FSM to IDLE and set RAM_READDATA, RAM_RVALID, RAM_BUSY, CLEAR_DONE, LINES_CLEARED and LINES_TOTAL to 0.
REQ-036 SHALL abort an in-progress run with no partial shift retained beyond the reset board contents when reset asserts mid-run.

Configuration
REQ-037 SHALL, with macro BOARD_LINE_TOTAL_EN defined, include the LINES_TOTAL counter.
REQ-038 SHALL, without BOARD_LINE_TOTAL_EN, keep the LINES_TOTAL port tied to 16'd0 and instantiate no counter.

Structure
REQ-039 SHALL take ROWS default, CELL_W, WALL_ROW, FLOOR_ROW, WALL_MASK, the cell type and the FSM state enum from the shared package polytris_pkg.
REQ-040 SHALL implement the full-row test in the combinational sub-module board_row_full (32-bit row in, full flag out).

Verification
REQ-041 SHALL verify: after reset, RAM_RE at addr 5 -> next cycle RAM_READDATA = 32'hFC00_003F and RAM_RVALID = 1; addr 30 -> 32'hFFFF_FFFF.
REQ-042 SHALL verify: write 32'h0000_0000 to row 3, then read it -> 32'hFC00_003F (walls forced); write to addr 23 -> row 23 unchanged.
REQ-043 SHALL verify: row 22 full and row 21 = 32'hFC55_403F, then CLEARLINE -> CLEAR_DONE with LINES_CLEARED = 1, row 22 = 32'hFC55_403F, row 0 = wall row.
REQ-044 SHALL verify: rows 19-22 full, then CLEARLINE -> LINES_CLEARED = 4, LINES_TOTAL = 4 (macro on) or 0 (macro off).
REQ-045 SHALL verify: RAM_RE during RAM_BUSY -> no RAM_RVALID; same-cycle RAM_RE/RAM_WE on row 7 -> old data returned.
REQ-046 SHALL verify: CLEARALL in the middle of SHIFT -> board reset, no CLEAR_DONE, RAM_BUSY low the next cycle.
